// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: EX-stage sequencer for the multi-cycle multiplier.
// Holds operands stable for a full multiplier run, stalls the pipeline
// until the result is back, and returns a repeated identical multiply
// from a one-entry last-result cache with no extra cycles.
//
// Handshake: a request is m_req & !flush while IDLE.  The request is
// consumed (EX/MEM may load) in the cycle ex_stall is low and
// result_valid is high.  A miss raises ex_stall in the request cycle and
// keeps it high until the DONE cycle, where result_valid presents the
// result.  DONE is held while pipe_stall is high.  Dropping m_req or
// raising flush while BUSY aborts the run.
module mul_issue_ctrl #(
    parameter int WIDTH    = 32,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m_req,
    input  logic [2:0]       m_funct3,
    input  logic [WIDTH-1:0] rs1_in,
    input  logic [WIDTH-1:0] rs2_in,
    input  logic             flush,
    input  logic             pipe_stall,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_out,
    output logic             is_mul,
    output logic [WIDTH-1:0] mul_rs1,
    output logic [WIDTH-1:0] mul_rs2,
    output logic [2:0]       mul_funct3,
    output logic             ex_stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] m_result,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_rs1;
    logic [WIDTH-1:0] r_rs2;
    logic [2:0]       r_f3;
    logic [WIDTH-1:0] r_result;

    logic             r_c_valid;
    logic [WIDTH-1:0] r_c_rs1;
    logic [WIDTH-1:0] r_c_rs2;
    logic [2:0]       r_c_f3;
    logic [WIDTH-1:0] r_c_result;

    logic             w_accept;
    logic             w_hit;
    logic             w_latch;
    logic             w_capture;

    // Full tag compare: operands and funct3 must all match, so no aliasing.
    assign w_accept  = m_req && !flush;
    assign w_hit     = CACHE_EN && r_c_valid && (rs1_in == r_c_rs1) &&
                       (rs2_in == r_c_rs2) && (m_funct3 == r_c_f3);
    assign w_latch   = (r_state == S_IDLE) && w_accept && !w_hit;
    // Flush (or a vanished request) beats a coincident mul_done.
    assign w_capture = (r_state == S_BUSY) && w_accept && mul_done;

    assign is_mul      = (r_state == S_BUSY);
    assign mul_rs1     = r_rs1;
    assign mul_rs2     = r_rs2;
    assign mul_funct3  = r_f3;
    assign o_dbg_state = r_state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and pipeline-facing outputs.
    always_comb begin
        w_next       = r_state;
        ex_stall     = 1'b0;
        result_valid = 1'b0;
        m_result     = r_result;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_hit) begin
                        result_valid = 1'b1;
                        m_result     = r_c_result;
                    end else begin
                        ex_stall = 1'b1;
                        w_next   = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (!w_accept) begin
                    w_next = S_IDLE;
                end else begin
                    ex_stall = 1'b1;
                    if (mul_done) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                if (flush || !pipe_stall) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Held operands: loaded only on an accepted miss, stable for the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_f3  <= 3'b000;
        end else if (w_latch) begin
            r_rs1 <= rs1_in;
            r_rs2 <= rs2_in;
            r_f3  <= m_funct3;
        end
    end

    // Result register and cache entry, written together when a run completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result   <= '0;
            r_c_valid  <= 1'b0;
            r_c_rs1    <= '0;
            r_c_rs2    <= '0;
            r_c_f3     <= 3'b000;
            r_c_result <= '0;
        end else if (w_capture) begin
            r_result   <= mul_out;
            r_c_valid  <= 1'b1;
            r_c_rs1    <= r_rs1;
            r_c_rs2    <= r_rs2;
            r_c_f3     <= r_f3;
            r_c_result <= mul_out;
        end
    end

endmodule
